ad_nios_counter_seq_ctrl: RTL and testbench

- Sequencer and configuration front-end for the hard-mapped lcell counter chain (counter-mode cells driven by ena/sclr/sload).
- Owns the chain's control inputs: run/stop, prescaled enable ticks, start-value load, terminal-count detect, one-shot/continuous reload.
- Sits between the Nios register bus (simple slave) and the counter datapath. Raises an IRQ on terminal count.

---
 rtl/ad_nios_counter_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ad_nios_counter_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad_nios_counter_seq_ctrl.sv
// Sequencer and Nios register front-end for the lcell counter chain.
// Drives ena/sclr/sload, detects terminal count and raises a level IRQ.
module ad_nios_counter_seq_ctrl #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [15:0]          writedata,
    output logic [15:0]          readdata,
    output logic                 irq,
    input  logic                 ext_trig,
    input  logic [WIDTH-1:0]     cnt_value,
    output logic                 cnt_ena,
    output logic                 cnt_sclr,
    output logic                 cnt_sload,
    output logic [WIDTH-1:0]     cnt_load_data,
    output logic                 tc_pulse
);

    // state  | meaning
    // IDLE   | chain stopped, clear accepted
    // ARMED  | waiting for synchronized ext_trig rising edge
    // LOAD   | one cycle: chain loaded from LOAD register
    // RUN    | prescaled ticks advance chain until terminal count
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t state, next_state;

    logic                  ctrl_cont, ctrl_trig_en, ctrl_irq_en;
    logic                  status_tc;
    logic [WIDTH-1:0]      period_q, load_q;
    logic [PRESCALE_W-1:0] prescale_q, presc_cnt;
    logic                  trig_s1, trig_s2, trig_s3;
    logic                  sclr_q;
    logic [15:0]           rdata_mux;

    logic bus_wr, bus_rd, wr_ctrl, start_req, stop_req, clear_req, w1c_tc;
    logic trig_edge, tick, at_period;
    logic tc_nxt, irq_en_nxt;

    assign bus_wr    = chipselect & ~write_n;
    assign bus_rd    = chipselect & write_n;
    assign wr_ctrl   = bus_wr && (address == 3'd0);
    assign start_req = wr_ctrl & writedata[0];
    assign stop_req  = wr_ctrl & writedata[1];
    assign clear_req = wr_ctrl & writedata[5];
    assign w1c_tc    = bus_wr && (address == 3'd1) && writedata[0];

    assign trig_edge = trig_s2 & ~trig_s3;
    assign tick      = (state == S_RUN) && (presc_cnt == prescale_q);
    assign at_period = (cnt_value == period_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A stop in the same write as start overrides it.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_IDLE;
            S_ARMED: if (trig_edge) next_state = S_LOAD;
            S_LOAD:  next_state = S_RUN;
            S_RUN:   if (tick && at_period && !ctrl_cont) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (start_req) next_state = writedata[3] ? S_ARMED : S_LOAD;
        if (stop_req)  next_state = S_IDLE;
    end

    always_comb begin
        cnt_ena   = 1'b0;
        tc_pulse  = 1'b0;
        cnt_sload = 1'b0;
        case (state)
            S_LOAD: cnt_sload = 1'b1;
            S_RUN: begin
                cnt_ena   = tick & ~at_period;
                tc_pulse  = tick & at_period;
                cnt_sload = tick & at_period & ctrl_cont;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
        end else if (state != S_RUN || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= ext_trig;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_cont    <= 1'b0;
            ctrl_trig_en <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            period_q     <= '0;
            prescale_q   <= '0;
            load_q       <= '0;
        end else if (bus_wr) begin
            case (address)
                3'd0: begin
                    ctrl_cont    <= writedata[2];
                    ctrl_trig_en <= writedata[3];
                    ctrl_irq_en  <= writedata[4];
                end
                3'd2: period_q   <= writedata[WIDTH-1:0];
                3'd3: prescale_q <= writedata[PRESCALE_W-1:0];
                3'd4: load_q     <= writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Terminal-count set beats a simultaneous write-1-clear.
    assign tc_nxt     = tc_pulse | (status_tc & ~w1c_tc);
    assign irq_en_nxt = wr_ctrl ? writedata[4] : ctrl_irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_tc <= 1'b0;
            irq       <= 1'b0;
            sclr_q    <= 1'b0;
        end else begin
            status_tc <= tc_nxt;
            irq       <= tc_nxt & irq_en_nxt;
            sclr_q    <= clear_req && (state == S_IDLE) && (next_state == S_IDLE);
        end
    end

    assign cnt_sclr      = sclr_q;
    assign cnt_load_data = load_q;

    always_comb begin
        rdata_mux = '0;
        case (address)
            3'd0: rdata_mux = {11'b0, ctrl_irq_en, ctrl_trig_en, ctrl_cont, 2'b00};
            3'd1: rdata_mux = {13'b0, (state == S_ARMED), (state == S_RUN), status_tc};
            3'd2: rdata_mux = 16'(period_q);
            3'd3: rdata_mux = 16'(prescale_q);
            3'd4: rdata_mux = 16'(load_q);
            3'd5: rdata_mux = 16'(cnt_value);
            default: rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (bus_rd) begin
            readdata <= rdata_mux;
        end
    end

endmodule

// File: tb/tb_ad_nios_counter_seq_ctrl.sv
// Directed bench for ad_nios_counter_seq_ctrl with a behavioural lcell counter chain.
module tb_ad_nios_counter_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    logic        ext_trig;
    logic [15:0] cnt_value;
    logic        cnt_ena;
    logic        cnt_sclr;
    logic        cnt_sload;
    logic [15:0] cnt_load_data;
    logic        tc_pulse;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    ad_nios_counter_seq_ctrl #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .irq           (irq),
        .ext_trig      (ext_trig),
        .cnt_value     (cnt_value),
        .cnt_ena       (cnt_ena),
        .cnt_sclr      (cnt_sclr),
        .cnt_sload     (cnt_sload),
        .cnt_load_data (cnt_load_data),
        .tc_pulse      (tc_pulse)
    );

    always #5 clk = ~clk;

    // External counter chain: not reset by the controller.
    initial cnt_value = 16'h1234;
    always @(posedge clk) begin
        if (cnt_sclr)       cnt_value <= '0;
        else if (cnt_sload) cnt_value <= cnt_load_data;
        else if (cnt_ena)   cnt_value <= cnt_value + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0;
        d = readdata;
    endtask

    initial begin
        logic [15:0] r;
        int          m;
        int          n;
        int          cnt_hits;
        logic        found;

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0; ext_trig = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 16'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ena", cnt_ena, 1'b0);
        chk("rst_sclr", cnt_sclr, 1'b0);
        chk("rst_sload", cnt_sload, 1'b0);
        chk("rst_tc", tc_pulse, 1'b0);
        reset_n = 1'b1;
        rd(3'd1, r); chk("rst_status", r, 16'h0000);
        rd(3'd5, r); chk("rst_count", r, 16'h1234);

        // one-shot, no prescale
        wr(3'd4, 16'd0); wr(3'd2, 16'd3); wr(3'd3, 16'd0);
        wr(3'd0, 16'h0011);
        chk("os_sload", cnt_sload, 1'b1);
        chk("os_sload_ena", cnt_ena, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("os_ena", cnt_ena, 1'b1);
            chk("os_ena_tc", tc_pulse, 1'b0);
        end
        @(negedge clk);
        chk("os_tc", tc_pulse, 1'b1);
        chk("os_tc_ena", cnt_ena, 1'b0);
        chk("os_tc_sload", cnt_sload, 1'b0);
        @(negedge clk);
        chk("os_irq", irq, 1'b1);
        chk("os_tc_after", tc_pulse, 1'b0);
        rd(3'd1, r); chk("os_status", r, 16'h0001);
        rd(3'd5, r); chk("os_count_hold", r, 16'd3);
        rd(3'd0, r); chk("os_ctrl_rb", r, 16'h0010);
        wr(3'd1, 16'h0001);
        chk("os_irq_clr", irq, 1'b0);

        // continuous, prescale 2: tick every 3 cycles, tc every 9
        wr(3'd4, 16'd5); wr(3'd2, 16'd7); wr(3'd3, 16'd2);
        wr(3'd0, 16'h0005);
        chk("ct_sload0", cnt_sload, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            m = k % 9;
            if (m == 0) m = 9;
            chk("ct_value", cnt_value, 16'(5 + (m - 1) / 3));
            chk("ct_ena", cnt_ena, ((k % 3 == 0) && (k % 9 != 0)) ? 1'b1 : 1'b0);
            chk("ct_tc", tc_pulse, (k % 9 == 0) ? 1'b1 : 1'b0);
            chk("ct_sload", cnt_sload, (k % 9 == 0) ? 1'b1 : 1'b0);
            chk("ct_excl", cnt_ena & cnt_sload, 1'b0);
        end
        chk("ct_irq_masked", irq, 1'b0);
        wr(3'd1, 16'h0001);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tc_pulse) found = 1'b1;
        end
        chk("ct_tc_found", found, 1'b1);
        chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 16'h0001;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        rd(3'd1, r); chk("ct_set_wins", r, 16'h0003);
        wr(3'd0, 16'h0002);
        rd(3'd1, r); chk("ct_stopped", r, 16'h0001);
        wr(3'd1, 16'h0001);
        rd(3'd1, r); chk("ct_cleared", r, 16'h0000);

        // triggered start
        wr(3'd0, 16'h0009);
        rd(3'd1, r); chk("tr_armed", r, 16'h0004);
        ext_trig = 1'b1;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(negedge clk);
            if (cnt_sload) n = i;
        end
        chk("tr_latency", (n >= 3 && n <= 4) ? 1'b1 : 1'b0, 1'b1);
        wr(3'd0, 16'h0002);
        ext_trig = 1'b0;
        rd(3'd1, r); chk("tr_stop_run", r, 16'h0000);
        repeat (4) @(negedge clk);
        wr(3'd0, 16'h0009);
        rd(3'd1, r); chk("tr_rearmed", r, 16'h0004);
        wr(3'd0, 16'h0002);
        rd(3'd1, r); chk("tr_disarmed", r, 16'h0000);
        ext_trig = 1'b1;
        cnt_hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cnt_sload) cnt_hits++;
        end
        chk("tr_no_load", cnt_hits, 0);
        ext_trig = 1'b0;

        // simultaneous start+stop, clear gating
        wr(3'd0, 16'h0003);
        chk("ss_no_sload", cnt_sload, 1'b0);
        rd(3'd1, r); chk("ss_idle", r, 16'h0000);
        wr(3'd0, 16'h0005);
        repeat (2) @(negedge clk);
        wr(3'd0, 16'h0020);
        chk("clr_run_a", cnt_sclr, 1'b0);
        @(negedge clk);
        chk("clr_run_b", cnt_sclr, 1'b0);
        wr(3'd0, 16'h0002);
        wr(3'd0, 16'h0020);
        chk("clr_idle_hi", cnt_sclr, 1'b1);
        @(negedge clk);
        chk("clr_idle_lo", cnt_sclr, 1'b0);
        rd(3'd5, r); chk("clr_count", r, 16'h0000);

        // PERIOD == LOAD: terminal count on the first tick
        wr(3'd4, 16'd9); wr(3'd2, 16'd9); wr(3'd3, 16'd0);
        wr(3'd0, 16'h0001);
        chk("eq_sload", cnt_sload, 1'b1);
        @(negedge clk);
        chk("eq_tc", tc_pulse, 1'b1);
        chk("eq_ena", cnt_ena, 1'b0);
        rd(3'd1, r); chk("eq_status", r, 16'h0001);
        wr(3'd1, 16'h0001);

        // reset during RUN
        wr(3'd4, 16'd0); wr(3'd2, 16'hFFFF); wr(3'd3, 16'd0);
        wr(3'd0, 16'h0005);
        @(negedge clk);
        chk("mr_ena_before", cnt_ena, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_ena_async", cnt_ena, 1'b0);
        chk("mr_sload_async", cnt_sload, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt_hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cnt_ena || cnt_sload || tc_pulse) cnt_hits++;
        end
        chk("mr_quiet", cnt_hits, 0);
        rd(3'd1, r); chk("mr_status", r, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
